// File: rtl/quad_log_pkg.sv
// Shared types and constants for the quadrature sample logger.
// The WRITE_TS state is only reachable with QUAD_LOG_TIMESTAMP_EN defined.
package quad_log_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE_TS = 2'd1,
        WRITE    = 2'd2
    } state_t;

    localparam logic [15:0] OVF_MAX    = 16'hFFFF;
    localparam logic [3:0]  BYTEEN_ALL = 4'hF;
    localparam int          WORD_SHIFT = 2;

    // Byte address of a log word, before truncation to the master width.
    function automatic logic [31:0] word_byte_addr(
        input logic [31:0] base,
        input logic [12:0] idx
    );
        return base + ({19'd0, idx} << WORD_SHIFT);
    endfunction

endpackage

// File: rtl/quad_log_fifo.sv
// Small synchronous FIFO with registered count and show-ahead output.
// Pushes while full and pops while empty are ignored.
module quad_log_fifo
    import quad_log_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/quad_sample_logger.sv
// Avalon-MM write master logging quadrature samples as a circular log.
// Optional: define QUAD_LOG_TIMESTAMP_EN to prefix each sample with a cycle stamp.
module quad_sample_logger
    import quad_log_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH_WORDS = 5120,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [31:0]       sample_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic [12:0]       wr_index,
    output logic              wrapped,
    output logic [15:0]       overflow_count,
    output logic              busy
);

`ifdef QUAD_LOG_TIMESTAMP_EN
    localparam int ENTRY_W = 64;
    localparam state_t FIRST = WRITE_TS;
`else
    localparam int ENTRY_W = 32;
    localparam state_t FIRST = WRITE;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [12:0] LAST_IDX = 13'(DEPTH_WORDS - 1);

    state_t             state_q;
    state_t             state_d;
    logic               en_q;
    logic               en_rise;
    logic               push;
    logic               drop;
    logic               pop;
    logic               load;
    logic               beat_done;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic [ENTRY_W-1:0] din;
    logic [ENTRY_W-1:0] dout;
    logic [12:0]        idx_next;
    logic               wrap_now;

    assign en_rise        = enable & ~en_q;
    assign push           = sample_valid & enable;
    assign drop           = push & full;
    assign beat_done      = avm_write & ~avm_waitrequest;
    assign wrap_now       = (wr_index == LAST_IDX);
    assign idx_next       = wrap_now ? 13'd0 : wr_index + 13'd1;
    assign avm_byteenable = BYTEEN_ALL;
    assign busy           = (count != '0) | avm_write;

`ifdef QUAD_LOG_TIMESTAMP_EN
    logic [31:0] ts_count;
    logic [31:0] data_hold;

    assign din = {ts_count, sample_data};

    // Free-running cycle stamp and the data half of the popped entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_count  <= '0;
            data_hold <= '0;
        end else begin
            ts_count <= ts_count + 32'd1;
            if (load) begin
                data_hold <= dout[31:0];
            end
        end
    end
`else
    assign din = sample_data;
`endif

    quad_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .dout    (dout),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; IDLE pops the FIFO head into the bus registers.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = FIRST;
                end
            end
`ifdef QUAD_LOG_TIMESTAMP_EN
            WRITE_TS: begin
                if (!avm_waitrequest) begin
                    state_d = WRITE;
                end
            end
`endif
            WRITE: begin
                if (!avm_waitrequest) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Avalon request registers, held stable while the slave stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avm_write     <= 1'b0;
            avm_address   <= ADDR_W'(BASE_ADDR);
            avm_writedata <= '0;
        end else if (load) begin
            avm_write     <= 1'b1;
            avm_address   <= ADDR_W'(word_byte_addr(32'(BASE_ADDR), wr_index));
            avm_writedata <= dout[ENTRY_W-1 -: 32];
`ifdef QUAD_LOG_TIMESTAMP_EN
        end else if (state_q == WRITE_TS && !avm_waitrequest) begin
            avm_address   <= ADDR_W'(word_byte_addr(32'(BASE_ADDR), idx_next));
            avm_writedata <= data_hold;
`endif
        end else if (beat_done) begin
            avm_write <= 1'b0;
        end
    end

    // Registered enable for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= enable;
        end
    end

    // Log position and wrap flag; a fresh enable restarts the log.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_index <= '0;
            wrapped  <= 1'b0;
        end else if (en_rise) begin
            wr_index <= '0;
            wrapped  <= 1'b0;
        end else if (beat_done) begin
            wr_index <= idx_next;
            if (wrap_now) begin
                wrapped <= 1'b1;
            end
        end
    end

    // Saturating count of samples lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_count <= '0;
        end else if (en_rise) begin
            overflow_count <= {15'd0, drop};
        end else if (drop && overflow_count != OVF_MAX) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_quad_sample_logger.sv
// Self-checking bench: directed scenarios plus random traffic,
// compared every cycle against a queue-based transaction model.
module tb_quad_sample_logger;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic [31:0]   sample_data = '0;
    logic [AW-1:0] avm_address;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest = 1'b0;
    logic [12:0]   wr_index;
    logic          wrapped;
    logic [15:0]   overflow_count;
    logic          busy;

    int n_tests = 0;
    int n_fail = 0;

    quad_sample_logger #(
        .ADDR_W      (AW),
        .BASE_ADDR   (0),
        .DEPTH_WORDS (DW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .wr_index        (wr_index),
        .wrapped         (wrapped),
        .overflow_count  (overflow_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction model: pending samples, one write in flight, log state.
    logic [31:0] mq[$];
    logic [31:0] seen_a[$];
    logic [31:0] seen_d[$];
    bit          started = 0;
    bit          m_wr = 0;
    bit          m_en = 0;
    bit          m_wrapped = 0;
    logic [31:0] m_cur = '0;
    logic [31:0] m_addr = '0;
    int          m_idx = 0;
    int          m_ovf = 0;

    always @(negedge clk) begin
        bit full, acc, drp, rise;
        if (started) begin
            check("avm_write", 64'(avm_write), 64'(m_wr));
            if (m_wr) begin
                check("avm_address", 64'(avm_address), 64'(m_addr));
                check("avm_writedata", 64'(avm_writedata), 64'(m_cur));
                check("avm_byteenable", 64'(avm_byteenable), 64'hF);
            end
            check("wr_index", 64'(wr_index), 64'(m_idx));
            check("wrapped", 64'(wrapped), 64'(m_wrapped));
            check("overflow_count", 64'(overflow_count), 64'(m_ovf));
            check("busy", 64'(busy), 64'(mq.size() != 0 || m_wr));
            if (reset_n && avm_write && !avm_waitrequest) begin
                seen_a.push_back(32'(avm_address));
                seen_d.push_back(avm_writedata);
            end
        end
        if (!reset_n) begin
            mq.delete();
            m_wr = 0;
            m_en = 0;
            m_wrapped = 0;
            m_idx = 0;
            m_ovf = 0;
            started = 1;
        end else begin
            full = (mq.size() >= FD);
            acc  = sample_valid && enable && !full;
            drp  = sample_valid && enable && full;
            rise = enable && !m_en;
            if (m_wr && !avm_waitrequest) begin
                m_wr = 0;
                if (m_idx == DW - 1) begin
                    m_idx = 0;
                    m_wrapped = 1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end else if (!m_wr && mq.size() > 0) begin
                m_cur  = mq.pop_front();
                m_addr = 32'(m_idx * 4);
                m_wr   = 1;
            end
            if (drp && m_ovf < 65535) m_ovf = m_ovf + 1;
            if (rise) begin
                m_idx = 0;
                m_wrapped = 0;
                m_ovf = drp ? 1 : 0;
            end
            if (acc) mq.push_back(sample_data);
            m_en = enable;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        cyc(1);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            cyc(1);
            k++;
        end
        if (k >= 300) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic toggle_enable();
        enable = 1'b0;
        cyc(2);
        enable = 1'b1;
        cyc(2);
    endtask

    initial begin
        cyc(3);
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_index", 64'(wr_index), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        enable = 1'b1;
        cyc(2);

        // Basic: three spaced samples, no stall.
        seen_a.delete(); seen_d.delete();
        strobe(32'h11); cyc(3);
        strobe(32'h22); cyc(3);
        strobe(32'h33);
        wait_idle();
        check("basic_n", 64'(seen_a.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("basic_addr", 64'(seen_a[i]), 64'(4 * i));
            check("basic_data", 64'(seen_d[i]), 64'(32'h11 * (i + 1)));
        end
        check("basic_index", 64'(wr_index), 64'd3);

        // Stall: waitrequest high for 5 cycles on one write.
        seen_a.delete(); seen_d.delete();
        avm_waitrequest = 1'b1;
        strobe(32'hA5);
        cyc(1);
        check("stall_write", 64'(avm_write), 64'd1);
        cyc(5);
        avm_waitrequest = 1'b0;
        wait_idle();
        check("stall_n", 64'(seen_a.size()), 64'd1);
        check("stall_addr", 64'(seen_a[0]), 64'hC);
        check("stall_data", 64'(seen_d[0]), 64'hA5);

        // Overflow: 7 back-to-back samples against a stalled slave.
        seen_a.delete(); seen_d.delete();
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 7; i++) strobe(32'h100 + 32'(i));
        check("ovf_count", 64'(overflow_count), 64'd2);
        avm_waitrequest = 1'b0;
        wait_idle();
        check("ovf_n", 64'(seen_a.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check("ovf_data", 64'(seen_d[i]), 64'(32'h100 + 32'(i)));
        check("ovf_wrap_addr", 64'(seen_a[4]), 64'd0);
        check("ovf_wrapped", 64'(wrapped), 64'd1);

        // Enable toggle clears log status.
        toggle_enable();
        check("tog_index", 64'(wr_index), 64'd0);
        check("tog_wrapped", 64'(wrapped), 64'd0);
        check("tog_ovf", 64'(overflow_count), 64'd0);

        // Wrap: ten samples into an eight-word log.
        seen_a.delete(); seen_d.delete();
        for (int i = 0; i < 10; i++) begin
            strobe(32'h200 + 32'(i));
            cyc(2);
        end
        wait_idle();
        check("wrap_n", 64'(seen_a.size()), 64'd10);
        check("wrap_addr8", 64'(seen_a[8]), 64'd0);
        check("wrap_addr9", 64'(seen_a[9]), 64'd4);
        check("wrap_data9", 64'(seen_d[9]), 64'h209);
        check("wrap_flag", 64'(wrapped), 64'd1);
        check("wrap_index", 64'(wr_index), 64'd2);

        // Reset during a stalled write.
        avm_waitrequest = 1'b1;
        strobe(32'h77);
        cyc(2);
        reset_n = 1'b0;
        cyc(1);
        check("rmid_write", 64'(avm_write), 64'd0);
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_index", 64'(wr_index), 64'd0);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        cyc(1);
        seen_a.delete(); seen_d.delete();
        strobe(32'h88);
        wait_idle();
        check("rmid_n", 64'(seen_a.size()), 64'd1);
        check("rmid_addr", 64'(seen_a[0]), 64'd0);
        check("rmid_data", 64'(seen_d[0]), 64'h88);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            sample_valid    = 1'($urandom_range(0, 1));
            sample_data     = $urandom;
            avm_waitrequest = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            cyc(1);
        end
        sample_valid = 1'b0;
        avm_waitrequest = 1'b0;
        enable = 1'b1;
        wait_idle();
        toggle_enable();
        check("end_index", 64'(wr_index), 64'd0);
        check("end_ovf", 64'(overflow_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
